eprisc_core_v1: RTL and testbench
=================================

EPRISC_CORE_V1 -- requirements
Module: epRISC_core

Interface
REQ-001 SHALL have no parameters; data/address width fixed at 32 bits, register file fixed at 16 x 32.
REQ-002 iClock  input  1  single core clock; all state changes on rising edge.
REQ-003 iReset  input  1  asynchronous, active-low reset.
REQ-004 oAddress  output  32  word address on the front-side bus.
REQ-005 bData  inout  32  bus data; driven by the core only while oWrite=1, otherwise high-Z.
REQ-006 oWrite  output  1  1 = store cycle.
REQ-007 iInterrupt  input  1  maskable interrupt, level-sensitive.
REQ-008 iNMInterrupt  input  1  non-maskable interrupt, rising-edge-sensitive.
REQ-009 oHalt  output  1  core halted.
REQ-010 oFlag  output  1  software-controlled status flag.

Function
REQ-011 Addressing SHALL be word-based; PC increments by 1 per instruction; all arithmetic SHALL be modulo 2^32.
REQ-012 States SHALL be FETCH, EXECUTE, MEMORY, HALT; non-memory instructions take 2 cycles, LOAD/STORE take 3 cycles.
REQ-013 FETCH: oAddress=PC, oWrite=0; instruction latched from bData on the next rising edge -> EXECUTE.
REQ-014 MEMORY: oAddress=effective address; LOAD latches bData into rd at the edge ending MEMORY; STORE asserts oWrite=1 and drives rd onto bData for exactly that one cycle.
REQ-015 In all non-MEMORY states oAddress SHALL equal PC.
REQ-016 Instruction fields: op[31:28], rd[27:24], ra[23:20], rb[19:16], func[3:0], imm16[15:0]; r0 SHALL read 0 and ignore writes.
REQ-017 op 0 NOP; op 1 ALU rd=ra func rb; op 2 ALU-immediate rd=ra func zero-extended imm16, func taken from [19:16].
REQ-018 ALU funcs: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by b[4:0], 6 SHR logical by b[4:0], 7 NOT a, 8 CMP (SUB with result discarded).
REQ-019 ALU ops SHALL update Z (result==0), N (result[31]), C (carry-out of ADD; borrow of SUB/CMP; 0 for the others); no other op SHALL alter flags.
REQ-020 op 3 LDI: bit 16=0 -> rd={16'h0,imm16}; bit 16=1 -> rd[31:16]=imm16, rd[15:0] kept.
REQ-021 op 4 LOAD rd=mem[ra+sext(imm16)]; op 5 STORE mem[ra+sext(imm16)]=rd.
REQ-022 op 6 BRANCH: cond[27:24] 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N; if taken, PC=PC+1+sext(instr[23:0]), else PC+1.
REQ-023 op 7 JUMP: rd=PC+1 (link), then PC=ra; the link SHALL be written even when rd=ra, with the jump using the old ra.
REQ-024 op 8 HALT -> HALT state, oHalt=1; exit only by reset or an accepted interrupt (oHalt clears, PC of the halt+1 saved).
REQ-025 op 9 FLAG: oFlag=instr[0]; op A RETI: PC=EPC, IE=1; op B IE=instr[0]; ops C-F SHALL execute as NOP.
REQ-026 Interrupt check SHALL occur at entry to FETCH: pending NMI (latched rising edge) first -> EPC=PC, IE=0, PC=0x8; else iInterrupt=1 with IE=1 -> EPC=PC, IE=0, PC=0x10; entry costs one cycle with no bus write.
REQ-027 An NMI edge occurring mid-instruction SHALL be held pending and never lost; simultaneous NMI and IRQ SHALL take the NMI.

Reset
REQ-028 While iReset=0 (asynchronously): PC=0, EPC=0, all registers 0, Z=N=C=0, IE=0, NMI pending cleared, state FETCH, oWrite=0, oHalt=0, oFlag=0, bData high-Z, oAddress=0.
REQ-029 A reset asserted mid-STORE SHALL drop oWrite and release bData immediately; the first fetch after release SHALL be from address 0.

Verification
REQ-030 LDI r1,5; ADDI r2,r1,3 -> r2=8, Z=0; fetches at 0,1 on consecutive 2-cycle boundaries.
REQ-031 r1=0xFFFFFFFF, ADD r3,r1,r1 with r1=1 in rb... (ADD r3,r1,r4 with r4=1) -> r3=0, Z=1, C=1; BRANCH Z +2 taken to PC+3.
REQ-032 STORE r2 -> [r0+0x1000] then LOAD r5 <- [0x1000] -> exactly one oWrite pulse with oAddress=0x1000, bData=8; r5=8.
REQ-033 IE=1, HALT, then iInterrupt=1 -> oHalt falls, next fetch at 0x10; RETI returns to halt address+1.
REQ-034 NMI rising edge during a LOAD with IE=0 -> next fetch at 0x8; CMP result discarded test: CMP r1,r1 -> Z=1, r1 unchanged.
REQ-035 Assert iReset low during a STORE -> oWrite=0 and bData=Z within the same cycle; after release, oAddress=0, oFlag=0, oHalt=0.

Source files
------------

// File: rtl/eprisc_core_v1.sv
// eprisc_core_v1: multi-cycle 32-bit word-addressed RISC core with a shared
// tristate data bus, maskable level IRQ and edge-triggered NMI.
module eprisc_core_v1 (
  input  logic        iClock,
  input  logic        iReset,
  output logic [31:0] oAddress,
  inout  wire  [31:0] bData,
  output logic        oWrite,
  input  logic        iInterrupt,
  input  logic        iNMInterrupt,
  output logic        oHalt,
  output logic        oFlag
);
  typedef enum logic [1:0] {FETCH, EXECUTE, MEMORY, HALT} stateType;
  stateType state, stateNext;
  logic [31:0] regs [16];
  logic [31:0] pc, epc, instr, a, b, aluRes, ea, pcInc, pcNext, wData;
  logic [32:0] sum, diff;
  logic [3:0] op, rd, ra, rb, func;
  logic z, n, c, ie, nmiPrev, nmiPend, aluCarry, taken, take, wEn, isAlu;
  assign {op, rd, ra, rb} = instr[31:16];
  assign isAlu = op == 4'h1 || op == 4'h2;
  assign func = op == 4'h1 ? instr[3:0] : rb;
  assign a = regs[ra];
  assign b = op == 4'h1 ? regs[rb] : {16'h0, instr[15:0]};
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign ea = a + {{16{instr[15]}}, instr[15:0]};
  assign pcInc = pc + 32'd1;
  // Interrupts are only accepted between instructions or while halted
  assign take = (state == FETCH || state == HALT) && (nmiPend || (iInterrupt && ie));
  assign oAddress = state == MEMORY ? ea : pc;
  assign oWrite = state == MEMORY && op == 4'h5;
  assign bData = oWrite ? regs[rd] : 32'bz;
  assign oHalt = state == HALT;
  always_comb begin
    aluRes = a;
    aluCarry = 1'b0;
    case (func)
      4'h0: {aluCarry, aluRes} = sum;
      4'h1, 4'h8: {aluCarry, aluRes} = diff;
      4'h2: aluRes = a & b;
      4'h3: aluRes = a | b;
      4'h4: aluRes = a ^ b;
      4'h5: aluRes = a << b[4:0];
      4'h6: aluRes = a >> b[4:0];
      4'h7: aluRes = ~a;
      default: aluRes = a;
    endcase
  end
  always_comb begin
    taken = 1'b0;
    case (rd)
      4'h0: taken = 1'b1;
      4'h1: taken = z;
      4'h2: taken = !z;
      4'h3: taken = c;
      4'h4: taken = !c;
      4'h5: taken = n;
      4'h6: taken = !n;
      default: taken = 1'b0;
    endcase
  end
  assign pcNext = op == 4'h6 && taken ? pcInc + {{8{instr[23]}}, instr[23:0]} :
                  op == 4'h7 ? a : op == 4'hA ? epc : pcInc;
  always_comb begin
    wEn = 1'b0;
    wData = aluRes;
    if (state == MEMORY) begin
      wEn = op == 4'h4;
      wData = bData;
    end else if (state == EXECUTE) begin
      case (op)
        4'h1, 4'h2: wEn = func != 4'h8;
        4'h3: begin
          wEn = 1'b1;
          wData = instr[16] ? {instr[15:0], regs[rd][15:0]} : {16'h0, instr[15:0]};
        end
        4'h7: begin
          wEn = 1'b1;
          wData = pcInc;
        end
        default: wEn = 1'b0;
      endcase
    end
  end
  always_comb begin
    stateNext = state;
    case (state)
      FETCH: stateNext = take ? FETCH : EXECUTE;
      EXECUTE: stateNext = op == 4'h4 || op == 4'h5 ? MEMORY : op == 4'h8 ? HALT : FETCH;
      MEMORY: stateNext = FETCH;
      HALT: stateNext = take ? FETCH : HALT;
      default: stateNext = FETCH;
    endcase
  end
  always_ff @(posedge iClock or negedge iReset)
    if (!iReset) state <= FETCH;
    else state <= stateNext;
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      pc <= '0;
      epc <= '0;
      instr <= '0;
      {z, n, c, ie, nmiPrev, nmiPend, oFlag} <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      nmiPrev <= iNMInterrupt;
      // A new edge arriving in the same cycle an NMI is accepted stays pending
      nmiPend <= (iNMInterrupt && !nmiPrev) || (nmiPend && !take);
      if (wEn && rd != 4'h0) regs[rd] <= wData;
      if (take) begin
        epc <= pc;
        ie <= 1'b0;
        pc <= nmiPend ? 32'h8 : 32'h10;
      end else if (state == FETCH) instr <= bData;
      else if (state == EXECUTE) begin
        pc <= pcNext;
        if (isAlu) {z, n, c} <= {aluRes == 32'h0, aluRes[31], aluCarry};
        if (op == 4'h9) oFlag <= instr[0];
        if (op == 4'hA) ie <= 1'b1;
        if (op == 4'hB) ie <= instr[0];
      end
    end
  end
endmodule

// File: tb/tb_eprisc_core_v1.sv
// tb_eprisc_core_v1: directed scenarios plus a randomized ALU/flag program
// checked against an instruction-level model of the core.
module tb_eprisc_core_v1;
  logic clk = 0, rstN = 0, irq = 0, nmi = 0;
  logic [31:0] addr;
  logic wr, halt, flag;
  wire [31:0] bus;
  logic [31:0] prog [4096];
  logic [31:0] dmem [4096];
  int checks = 0, failures = 0, wrCount = 0, at = 0, base = 0, n = 0;
  logic [31:0] m [8];
  logic [31:0] expS [24];
  logic [31:0] expP [192];
  logic [31:0] v, av, bv, r;
  logic [63:0] wide;
  logic [15:0] imm;
  logic [3:0] rd, ra, rb, f;
  logic mz, mn, mc, cc, useImm, tk;

  eprisc_core_v1 dut (.iClock(clk), .iReset(rstN), .oAddress(addr), .bData(bus), .oWrite(wr),
                      .iInterrupt(irq), .iNMInterrupt(nmi), .oHalt(halt), .oFlag(flag));

  always #5 clk = ~clk;
  assign bus = wr ? 32'bz : (addr[12] ? dmem[addr[11:0]] : prog[addr[11:0]]);

  always @(posedge clk)
    if (!rstN) for (int i = 0; i < 4096; i++) dmem[i] <= '0;
    else if (wr) begin
      dmem[addr[11:0]] <= bus;
      wrCount <= wrCount + 1;
    end

  function automatic logic [31:0] eLdi(input logic [3:0] d, input logic [15:0] k, input logic hi);
    return {4'h3, d, 7'h0, hi, k};
  endfunction
  function automatic logic [31:0] eAlu(input logic [3:0] d, s, t, fn);
    return {4'h1, d, s, t, 12'h0, fn};
  endfunction
  function automatic logic [31:0] eAlui(input logic [3:0] d, s, fn, input logic [15:0] k);
    return {4'h2, d, s, fn, k};
  endfunction
  function automatic logic [31:0] eLd(input logic [3:0] d, s, input logic [15:0] k);
    return {4'h4, d, s, 4'h0, k};
  endfunction
  function automatic logic [31:0] eSt(input logic [3:0] d, s, input logic [15:0] k);
    return {4'h5, d, s, 4'h0, k};
  endfunction
  function automatic logic [31:0] eBr(input logic [3:0] cond, input logic [23:0] off);
    return {4'h6, cond, off};
  endfunction
  function automatic logic [31:0] eJmp(input logic [3:0] d, s);
    return {4'h7, d, s, 20'h0};
  endfunction
  function automatic logic [31:0] eHalt();
    return {4'h8, 28'h0};
  endfunction
  function automatic logic [31:0] eFlag(input logic bit0);
    return {4'h9, 27'h0, bit0};
  endfunction
  function automatic logic [31:0] eReti();
    return {4'hA, 28'h0};
  endfunction
  function automatic logic [31:0] eIe(input logic bit0);
    return {4'hB, 27'h0, bit0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] w);
    prog[at] = w;
    at++;
  endtask

  task automatic clearProg();
    for (int i = 0; i < 4096; i++) prog[i] = '0;
    at = 0;
  endtask

  task automatic doReset();
    rstN = 0;
    irq = 0;
    nmi = 0;
    repeat (3) @(negedge clk);
    rstN = 1;
    #1;
  endtask

  task automatic runToHalt(input string tag, input int budget);
    int k = 0;
    while (!halt && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_halt"}, {31'h0, halt}, 1);
  endtask

  initial begin
    #12;
    chk("rst_addr", addr, 0);
    chk("rst_write", {31'h0, wr}, 0);
    chk("rst_halt", {31'h0, halt}, 0);
    chk("rst_flag", {31'h0, flag}, 0);

    clearProg();
    put(eLdi(1, 16'd5, 0)); put(eAlui(2, 1, 4'h0, 16'd3)); put(eSt(2, 0, 16'h1000));
    put(eLd(5, 0, 16'h1000)); put(eSt(5, 0, 16'h1001)); put(eBr(2, 24'd1));
    put(eHalt()); put(eFlag(1)); put(eHalt());
    doReset();
    base = wrCount;
    chk("a_fetch0", addr, 0);
    @(negedge clk); chk("a_exec0", addr, 0);
    @(negedge clk); chk("a_fetch1", addr, 1);
    @(negedge clk); chk("a_exec1", addr, 1);
    @(negedge clk); chk("a_fetch2", addr, 2);
    runToHalt("a", 100);
    chk("a_store", dmem[0], 8);
    chk("a_load", dmem[1], 8);
    chk("a_pulses", wrCount - base, 2);
    chk("a_zclear", {31'h0, flag}, 1);

    clearProg();
    put(eBr(0, 24'h1F));
    at = 'h20;
    put(eLdi(1, 16'hFFFF, 0)); put(eLdi(1, 16'hFFFF, 1)); put(eLdi(4, 16'd1, 0));
    put(eAlu(3, 1, 4, 4'h0)); put(eBr(1, 24'd2)); put(eHalt()); put(eHalt());
    put(eSt(3, 0, 16'h1000)); put(eBr(3, 24'd1)); put(eHalt());
    put(eAlu(1, 1, 1, 4'h8)); put(eBr(1, 24'd1)); put(eHalt());
    put(eSt(1, 0, 16'h1001)); put(eLdi(7, 16'h40, 0)); put(eJmp(7, 7)); put(eHalt());
    at = 'h40;
    put(eSt(7, 0, 16'h1002)); put(eFlag(1)); put(eHalt());
    doReset();
    base = wrCount;
    runToHalt("b", 200);
    chk("b_path", {31'h0, flag}, 1);
    chk("b_sum", dmem[0], 0);
    chk("b_cmpKeep", dmem[1], 32'hFFFFFFFF);
    chk("b_link", dmem[2], 32'h30);
    chk("b_pulses", wrCount - base, 3);

    clearProg();
    put(eBr(0, 24'h1F));
    at = 'h10;
    put(eFlag(1)); put(eReti());
    at = 'h20;
    put(eIe(1)); put(eHalt()); put(eLdi(1, 16'h77, 0)); put(eSt(1, 0, 16'h1000)); put(eHalt());
    doReset();
    runToHalt("c1", 50);
    chk("c_flag0", {31'h0, flag}, 0);
    irq = 1;
    @(negedge clk);
    chk("c_haltFall", {31'h0, halt}, 0);
    chk("c_vec", addr, 32'h10);
    irq = 0;
    runToHalt("c2", 100);
    chk("c_ret", dmem[0], 32'h77);
    chk("c_flag", {31'h0, flag}, 1);

    clearProg();
    put(eBr(0, 24'h1F));
    at = 8;
    put(eLdi(6, 16'h55, 0)); put(eSt(6, 0, 16'h1002)); put(eHalt());
    at = 'h20;
    put(eLdi(1, 16'h1000, 0)); put(eLd(2, 1, 16'h0)); put(eLdi(3, 16'h99, 0));
    put(eSt(3, 0, 16'h1003)); put(eHalt());
    doReset();
    n = 0;
    while (!(addr == 32'h1000 && !wr) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("d_inLoad", addr, 32'h1000);
    nmi = 1;
    @(negedge clk); chk("d_entry", addr, 32'h22);
    @(negedge clk); chk("d_vec", addr, 32'h8);
    runToHalt("d", 100);
    chk("d_handler", dmem[2], 32'h55);
    chk("d_skipped", dmem[3], 0);

    clearProg();
    put(eFlag(1)); put(eLdi(2, 16'h1234, 0)); put(eSt(2, 0, 16'h1000)); put(eHalt());
    doReset();
    n = 0;
    while (!wr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("e_inStore", {31'h0, wr}, 1);
    chk("e_flagSet", {31'h0, flag}, 1);
    rstN = 0;
    #1;
    chk("e_wrDrop", {31'h0, wr}, 0);
    chk("e_busFree", bus, prog[0]);
    chk("e_addr", addr, 0);
    chk("e_flag", {31'h0, flag}, 0);
    chk("e_halt", {31'h0, halt}, 0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1;
    #1;
    chk("e_fetch", addr, 0);

    clearProg();
    put(eBr(0, 24'h1F));
    at = 'h20;
    m[0] = 0;
    for (int i = 1; i < 8; i++) begin
      v = $urandom;
      m[i] = v;
      put(eLdi(4'(i), v[15:0], 0));
      put(eLdi(4'(i), v[31:16], 1));
    end
    for (int k = 0; k < 24; k++) begin
      rd = 4'($urandom_range(0, 7));
      ra = 4'($urandom_range(0, 7));
      rb = k % 5 == 4 ? ra : 4'($urandom_range(0, 7));
      f = 4'($urandom_range(0, 8));
      useImm = 1'($urandom_range(0, 1));
      imm = 16'($urandom);
      av = m[ra];
      bv = useImm ? {16'h0, imm} : m[rb];
      cc = 1'b0;
      case (f)
        4'h0: begin
          r = av + bv;
          wide = {32'h0, av} + {32'h0, bv};
          cc = wide > 64'hFFFFFFFF;
        end
        4'h1, 4'h8: begin
          r = av - bv;
          cc = av < bv;
        end
        4'h2: r = av & bv;
        4'h3: r = av | bv;
        4'h4: r = av ^ bv;
        4'h5: r = av << bv[4:0];
        4'h6: r = av >> bv[4:0];
        default: r = ~av;
      endcase
      mz = r == 0;
      mn = r[31];
      mc = cc;
      if (f != 4'h8 && rd != 0) m[rd] = r;
      put(useImm ? eAlui(rd, ra, f, imm) : eAlu(rd, ra, rb, f));
      put(eSt(rd, 0, 16'(16'h1000 + k)));
      expS[k] = m[rd];
      for (int cnd = 1; cnd <= 6; cnd++) begin
        tk = cnd == 1 ? mz : cnd == 2 ? !mz : cnd == 3 ? mc : cnd == 4 ? !mc : cnd == 5 ? mn : !mn;
        put(eLdi(8, 16'h0, 0));
        put(eBr(4'(cnd), 24'd1));
        put(eLdi(8, 16'h1, 0));
        put(eSt(8, 0, 16'(16'h1400 + k * 8 + cnd)));
        expP[k * 8 + cnd] = tk ? 0 : 1;
      end
    end
    put(eHalt());
    doReset();
    runToHalt("rnd", 6000);
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("rnd_res%0d", k), dmem[k], expS[k]);
      for (int cnd = 1; cnd <= 6; cnd++)
        chk($sformatf("rnd_cond%0d_%0d", k, cnd), dmem[12'h400 + k * 8 + cnd], expP[k * 8 + cnd]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
